// File: rtl/fp_mul_seq_param.sv
// Parametrised sequential floating-point multiplier.
// It uses a shift-add significand multiply with one operation in flight at a time.
// It provides round-to-nearest-even, special-value selection and overflow/underflow/invalid flags.
// Subnormal operands are treated as zero.
module fp_mul_seq_param #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned BIAS  = 127
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a_in,
  input  logic [EXP_W+MAN_W:0] b_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 flag_ovf,
  output logic                 flag_unf,
  output logic                 flag_inv
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned P  = MAN_W + 1;
  localparam int unsigned EW = EXP_W + 2;
  localparam int unsigned CW = $clog2(P) + 1;

  localparam logic [CW-1:0]        LAST_CNT = CW'(P - 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0]        BIAS_EXT = EW'(BIAS);
  localparam logic [EXP_W-1:0]     EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]         QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StNorm,
    StRound,
    StDone
  } state_e;

  state_e r_state, w_state_d;

  // Captured operands, shift-add working registers and per-stage results
  logic [W-1:0]            r_a, r_b;
  logic [P-1:0]            r_acc, r_mq;
  logic [CW-1:0]           r_cnt;
  logic [MAN_W-1:0]        r_man;
  logic                    r_g, r_r, r_s;
  logic signed [EW-1:0]    r_exp;
  logic [W-1:0]            r_result;
  logic                    r_ovf, r_unf, r_inv;

  // Operand fields and classes, taken from the captured copies
  logic                    w_sa, w_sb, w_sign;
  logic [EXP_W-1:0]        w_ea, w_eb;
  logic [MAN_W-1:0]        w_ma, w_mb;
  logic                    w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [P-1:0]            w_sig_a_in, w_sig_b;

  assign w_sa   = r_a[W-1];
  assign w_sb   = r_b[W-1];
  assign w_sign = w_sa ^ w_sb;
  assign w_ea   = r_a[W-2 -: EXP_W];
  assign w_eb   = r_b[W-2 -: EXP_W];
  assign w_ma   = r_a[MAN_W-1:0];
  assign w_mb   = r_b[MAN_W-1:0];

  assign w_a_zero = (w_ea == '0);
  assign w_b_zero = (w_eb == '0);
  assign w_a_inf  = (w_ea == EXP_ONES) && (w_ma == '0);
  assign w_b_inf  = (w_eb == EXP_ONES) && (w_mb == '0);
  assign w_a_nan  = (w_ea == EXP_ONES) && (w_ma != '0);
  assign w_b_nan  = (w_eb == EXP_ONES) && (w_mb != '0);

  // Hidden bit is set only for a non-zero exponent; zeros are overridden later anyway
  assign w_sig_a_in = {(a_in[W-2 -: EXP_W] != '0), a_in[MAN_W-1:0]};
  assign w_sig_b    = {(w_eb != '0), w_mb};

  // Shift-add step: conditionally add B, then shift {acc, A} right by one
  logic [P-1:0] w_add;
  logic [P:0]   w_sum;

  assign w_add = r_mq[0] ? w_sig_b : '0;
  assign w_sum = {1'b0, r_acc} + {1'b0, w_add};

  // Normalisation of the 2P-bit product and guard/round/sticky extraction
  logic [2*P-1:0]       w_prod;
  logic                 w_norm_inc;
  logic [MAN_W-1:0]     w_man_n;
  logic                 w_g_n, w_r_n, w_s_n;
  logic signed [EW-1:0] w_exp_n;

  assign w_prod     = {r_acc, r_mq};
  assign w_norm_inc = w_prod[2*P-1];
  assign w_exp_n    = EW'({2'b00, w_ea}) + EW'({2'b00, w_eb}) - BIAS_EXT
                    + {{(EW-1){1'b0}}, w_norm_inc};

  // Select mantissa window depending on whether the product reached [2,4)
  always_comb begin
    w_man_n = '0;
    w_g_n   = 1'b0;
    w_r_n   = 1'b0;
    w_s_n   = 1'b0;
    if (w_norm_inc) begin
      w_man_n = w_prod[2*P-2 -: MAN_W];
      w_g_n   = w_prod[P-1];
      w_r_n   = w_prod[P-2];
      w_s_n   = |w_prod[P-3:0];
    end else begin
      w_man_n = w_prod[2*P-3 -: MAN_W];
      w_g_n   = w_prod[P-2];
      w_r_n   = w_prod[P-3];
      w_s_n   = |w_prod[P-4:0];
    end
  end

  // Round to nearest, ties to even
  logic                 w_round_up;
  logic [MAN_W:0]       w_man_sum;
  logic [MAN_W-1:0]     w_man_r;
  logic signed [EW-1:0] w_exp_r;

  assign w_round_up = r_g & (r_r | r_s | r_man[0]);
  assign w_man_sum  = {1'b0, r_man} + {{MAN_W{1'b0}}, w_round_up};
  // On carry-out the stored mantissa bits are already all zero: 1.11..1 + ulp = 10.00..0
  assign w_man_r    = w_man_sum[MAN_W-1:0];
  assign w_exp_r    = r_exp + {{(EW-1){1'b0}}, w_man_sum[MAN_W]};

  // Final result and flag selection in priority order
  logic [W-1:0] w_res_d;
  logic         w_ovf_d, w_unf_d, w_inv_d;

  always_comb begin
    w_res_d = '0;
    w_ovf_d = 1'b0;
    w_unf_d = 1'b0;
    w_inv_d = 1'b0;
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_res_d = QNAN;
      w_inv_d = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_res_d = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_a_zero || w_b_zero) begin
      w_res_d = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (w_exp_r >= EXP_MAX) begin
      w_res_d = {w_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_ovf_d = 1'b1;
    end else if (w_exp_r[EW-1] || (w_exp_r == '0)) begin
      w_res_d = {w_sign, {(EXP_W+MAN_W){1'b0}}};
      w_unf_d = 1'b1;
    end else begin
      w_res_d = {w_sign, w_exp_r[EXP_W-1:0], w_man_r};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (in_valid) w_state_d = StMul;
      StMul:   if (r_cnt == LAST_CNT) w_state_d = StNorm;
      StNorm:  w_state_d = StRound;
      StRound: w_state_d = StDone;
      StDone:  if (out_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    in_ready  = (r_state == StIdle);
    out_valid = (r_state == StDone);
    result    = r_result;
    flag_ovf  = r_ovf;
    flag_unf  = r_unf;
    flag_inv  = r_inv;
  end

  // Datapath: capture, iterate, normalise, round, hold until handoff
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_mq     <= '0;
      r_cnt    <= '0;
      r_man    <= '0;
      r_g      <= 1'b0;
      r_r      <= 1'b0;
      r_s      <= 1'b0;
      r_exp    <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_inv    <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_mq  <= w_sig_a_in;
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        StMul: begin
          r_acc <= w_sum[P:1];
          r_mq  <= {w_sum[0], r_mq[P-1:1]};
          r_cnt <= r_cnt + 1'b1;
        end
        StNorm: begin
          r_man <= w_man_n;
          r_g   <= w_g_n;
          r_r   <= w_r_n;
          r_s   <= w_s_n;
          r_exp <= w_exp_n;
        end
        StRound: begin
          r_result <= w_res_d;
          r_ovf    <= w_ovf_d;
          r_unf    <= w_unf_d;
          r_inv    <= w_inv_d;
        end
        StDone: begin
          if (out_ready) begin
            r_result <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
            r_inv    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
